key_event_gen: RTL



---
 rtl/key_event_gen.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/key_event_gen.sv
// Turns debounced key levels into discrete key events with optional timed auto-repeat,
// buffered in a single-entry valid/ack slot. Auto-repeat is built when KEY_EVENT_AUTOREPEAT_EN is defined.
module key_event_gen #(
  parameter int NUM_KEYS      = 4,
  parameter int CODE_W        = 4,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] db_keys,
  input  logic                key_ack,
  output logic                key_valid,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_held,
  output logic                overrun,
  output logic [1:0]          dbg_state
);

  // Handshake: key_valid/key_code hold steady until a cycle with key_valid=1 and key_ack=1;
  // that cycle consumes the event. key_ack while key_valid=0 has no effect.

  if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_bad_num_keys
    $error("key_event_gen: NUM_KEYS must be in 1..16");
  end
  if ((1 << CODE_W) < NUM_KEYS) begin : g_bad_code_w
    $error("key_event_gen: CODE_W too narrow for NUM_KEYS");
  end
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
    $error("key_event_gen: REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HELD    = 2'd1,
`ifdef KEY_EVENT_AUTOREPEAT_EN
    ST_REPEAT  = 2'd2,
`endif
    ST_RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [CODE_W-1:0]   cur_q, cur_d;
  logic                valid_q, valid_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                held_q, held_d;
  logic                ovr_q, ovr_d;
  logic                ev;
  logic                cur_down;

`ifdef KEY_EVENT_AUTOREPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  function automatic logic [CODE_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = CODE_W'(i);
    end
  endfunction

  assign sync1_d  = db_keys;
  assign sync2_d  = sync1_q;
  assign cur_down = |(sync2_q & (NUM_KEYS'(1) << cur_q));

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ev      = 1'b0;
`ifdef KEY_EVENT_AUTOREPEAT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|sync2_q) begin
          cur_d   = lowest_idx(sync2_q);
          ev      = 1'b1;
          state_d = ST_HELD;
`ifdef KEY_EVENT_AUTOREPEAT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_HELD: begin
        if (!cur_down) begin
          state_d = ST_RELEASE;
`ifdef KEY_EVENT_AUTOREPEAT_EN
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
          ev      = 1'b1;
          cnt_d   = '0;
          state_d = ST_REPEAT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end
`ifdef KEY_EVENT_AUTOREPEAT_EN
      ST_REPEAT: begin
        if (!cur_down) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
          ev      = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`endif
      ST_RELEASE: begin
        // Other keys pressed during the hold are swallowed until everything is up.
        if (sync2_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovr_d   = ovr_q;
    if (ev) begin
      if (!valid_q || key_ack) begin
        valid_d = 1'b1;
        code_d  = cur_d;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (key_ack && valid_q) begin
      valid_d = 1'b0;
    end
`ifdef KEY_EVENT_AUTOREPEAT_EN
    held_d = (state_d == ST_HELD) || (state_d == ST_REPEAT);
`else
    held_d = (state_d == ST_HELD);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      cur_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      held_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef KEY_EVENT_AUTOREPEAT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      held_q  <= held_d;
      ovr_q   <= ovr_d;
`ifdef KEY_EVENT_AUTOREPEAT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_held  = held_q;
  assign overrun   = ovr_q;
  assign dbg_state = state_q;

endmodule
